alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU plus an optional iterative multiply/divide unit.
// Define ALU_MULDIV_EN to build the shift-add / restoring-division datapath.
module alu_muldiv #(
    parameter int LEN    = 32,
    parameter int LEN_OP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LEN-1:0]    A,
    input  logic [LEN-1:0]    B,
    input  logic [LEN_OP-1:0] OPCODE,
    output logic              out_valid,
    output logic [LEN-1:0]    RESULT_OUT,
    output logic [LEN-1:0]    HI_OUT,
    output logic              zero_flag,
    output logic              overflow_flag,
    output logic              div_by_zero
);

    localparam int SW = $clog2(LEN);
    localparam int CW = SW + 1;

    localparam logic [LEN_OP-1:0] OP_SLL   = LEN_OP'(0);
    localparam logic [LEN_OP-1:0] OP_SRL   = LEN_OP'(1);
    localparam logic [LEN_OP-1:0] OP_SRA   = LEN_OP'(2);
    localparam logic [LEN_OP-1:0] OP_ADD   = LEN_OP'(3);
    localparam logic [LEN_OP-1:0] OP_SLT   = LEN_OP'(4);
    localparam logic [LEN_OP-1:0] OP_AND   = LEN_OP'(5);
    localparam logic [LEN_OP-1:0] OP_OR    = LEN_OP'(6);
    localparam logic [LEN_OP-1:0] OP_XOR   = LEN_OP'(7);
    localparam logic [LEN_OP-1:0] OP_NOR   = LEN_OP'(8);
    localparam logic [LEN_OP-1:0] OP_LUI   = LEN_OP'(9);
    localparam logic [LEN_OP-1:0] OP_SUB   = LEN_OP'(10);
    localparam logic [LEN_OP-1:0] OP_MULT  = LEN_OP'(11);
    localparam logic [LEN_OP-1:0] OP_MULTU = LEN_OP'(12);
    localparam logic [LEN_OP-1:0] OP_DIV   = LEN_OP'(13);
    localparam logic [LEN_OP-1:0] OP_DIVU  = LEN_OP'(14);

    logic           accept;
    logic           md_route;
    logic           md_load;
    logic [LEN-1:0] md_lo;
    logic [LEN-1:0] md_hi;
    logic           md_dz;

    logic [SW-1:0]  shamt;
    logic [LEN-1:0] sum;
    logic [LEN-1:0] diff;
    logic [LEN-1:0] alu_res;
    logic           alu_of;
    logic           alu_zf;

    logic [LEN-1:0] res_q, res_d;
    logic [LEN-1:0] hi_q, hi_d;
    logic           zf_q, zf_d;
    logic           of_q, of_d;
    logic           dz_q, dz_d;
    logic           ov_q, ov_d;

    assign accept = in_valid && in_ready;
    assign shamt  = A[SW-1:0];
    assign sum    = A + B;
    assign diff   = A - B;

    // Single-cycle operation result and flags
    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        alu_zf  = 1'b0;
        unique case (OPCODE)
            OP_SLL: alu_res = B << shamt;
            OP_SRL: alu_res = B >> shamt;
            OP_SRA: alu_res = $unsigned($signed(B) >>> shamt);
            OP_ADD: begin
                alu_res = sum;
                alu_of  = (A[LEN-1] == B[LEN-1]) &&
                          (sum[LEN-1] != A[LEN-1]);
            end
            OP_SLT: begin
                alu_res = {{(LEN-1){1'b0}}, ($signed(A) < $signed(B))};
                alu_zf  = (A == B);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOR: alu_res = ~(A | B);
            OP_LUI: alu_res = B << (LEN / 2);
            OP_SUB: begin
                alu_res = diff;
                alu_of  = (A[LEN-1] != B[LEN-1]) &&
                          (diff[LEN-1] != A[LEN-1]);
            end
            default: alu_res = '0;
        endcase
    end

    // Output register next state: hold until the next completion
    always_comb begin
        res_d = res_q;
        hi_d  = hi_q;
        zf_d  = zf_q;
        of_d  = of_q;
        dz_d  = dz_q;
        ov_d  = 1'b0;
        if (md_load) begin
            res_d = md_lo;
            hi_d  = md_hi;
            zf_d  = 1'b0;
            of_d  = 1'b0;
            dz_d  = md_dz;
            ov_d  = 1'b1;
        end else if (accept && !md_route) begin
            res_d = alu_res;
            hi_d  = '0;
            zf_d  = alu_zf;
            of_d  = alu_of;
            dz_d  = 1'b0;
            ov_d  = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= '0;
            hi_q  <= '0;
            zf_q  <= 1'b0;
            of_q  <= 1'b0;
            dz_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            res_q <= res_d;
            hi_q  <= hi_d;
            zf_q  <= zf_d;
            of_q  <= of_d;
            dz_q  <= dz_d;
            ov_q  <= ov_d;
        end
    end

    assign RESULT_OUT    = res_q;
    assign HI_OUT        = hi_q;
    assign zero_flag     = zf_q;
    assign overflow_flag = of_q;
    assign div_by_zero   = dz_q;
    assign out_valid     = ov_q;

`ifdef ALU_MULDIV_EN

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LEN-1:0] ph_q, ph_d;
    logic [LEN-1:0] pl_q, pl_d;
    logic [LEN-1:0] bm_q, bm_d;
    logic [LEN-1:0] a_q, a_d;
    logic           nres_q, nres_d;
    logic           nrem_q, nrem_d;
    logic           dz0_q, dz0_d;

    logic             is_mul;
    logic             sgn;
    logic             busy;
    logic             last;
    logic [LEN-1:0]   a_mag;
    logic [LEN-1:0]   b_mag;
    logic [LEN:0]     msum;
    logic [LEN:0]     dsh;
    logic [LEN:0]     dsub;
    logic             dge;
    logic [2*LEN-1:0] prod;

    assign md_route = (OPCODE == OP_MULT) || (OPCODE == OP_MULTU) ||
                      (OPCODE == OP_DIV)  || (OPCODE == OP_DIVU);
    assign is_mul   = (OPCODE == OP_MULT) || (OPCODE == OP_MULTU);
    assign sgn      = (OPCODE == OP_MULT) || (OPCODE == OP_DIV);
    assign in_ready = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
    assign last     = (cnt_q == CW'(LEN));
    assign md_load  = busy && last;

    // Signed ops run on magnitudes; signs are restored at the end
    assign a_mag = (sgn && A[LEN-1]) ? -A : A;
    assign b_mag = (sgn && B[LEN-1]) ? -B : B;

    // Shift-add step: ph accumulates, pl holds the multiplier
    assign msum = {1'b0, ph_q} + (pl_q[0] ? {1'b0, bm_q} : '0);

    // Restoring step: ph is the partial remainder, pl the dividend/quotient
    assign dsh  = {ph_q, pl_q[LEN-1]};
    assign dsub = dsh - {1'b0, bm_q};
    assign dge  = (dsh >= {1'b0, bm_q});
    assign prod = {ph_q, pl_q};

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept && md_route) begin
                    state_d = is_mul ? S_MUL : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Iterative datapath next state: load on accept, then LEN steps
    always_comb begin
        cnt_d  = cnt_q;
        ph_d   = ph_q;
        pl_d   = pl_q;
        bm_d   = bm_q;
        a_d    = a_q;
        nres_d = nres_q;
        nrem_d = nrem_q;
        dz0_d  = dz0_q;
        if (accept && md_route) begin
            cnt_d  = '0;
            ph_d   = '0;
            pl_d   = a_mag;
            bm_d   = b_mag;
            a_d    = A;
            nres_d = sgn && (A[LEN-1] ^ B[LEN-1]);
            nrem_d = sgn && A[LEN-1];
            dz0_d  = !is_mul && (B == '0);
        end else if (busy && !last) begin
            cnt_d = cnt_q + 1'b1;
            if (state_q == S_MUL) begin
                ph_d = msum[LEN:1];
                pl_d = {msum[0], pl_q[LEN-1:1]};
            end else begin
                ph_d = dge ? dsub[LEN-1:0] : dsh[LEN-1:0];
                pl_d = {pl_q[LEN-2:0], dge};
            end
        end
    end

    // Final sign fix-up and divide-by-zero override
    always_comb begin
        md_lo = pl_q;
        md_hi = ph_q;
        md_dz = 1'b0;
        if (state_q == S_MUL) begin
            {md_hi, md_lo} = nres_q ? -prod : prod;
        end else begin
            md_lo = nres_q ? -pl_q : pl_q;
            md_hi = nrem_q ? -ph_q : ph_q;
            if (dz0_q) begin
                md_lo = '1;
                md_hi = a_q;
                md_dz = 1'b1;
            end
        end
    end

    // FSM and iterative datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            pl_q    <= '0;
            bm_q    <= '0;
            a_q     <= '0;
            nres_q  <= 1'b0;
            nrem_q  <= 1'b0;
            dz0_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            pl_q    <= pl_d;
            bm_q    <= bm_d;
            a_q     <= a_d;
            nres_q  <= nres_d;
            nrem_q  <= nrem_d;
            dz0_q   <= dz0_d;
        end
    end

`else

    assign md_route = 1'b0;
    assign md_load  = 1'b0;
    assign md_lo    = '0;
    assign md_hi    = '0;
    assign md_dz    = 1'b0;
    assign in_ready = 1'b1;

`endif

endmodule
